// File: rtl/alu_share_arbiter_if.sv
// Bundle between the ALU share arbiter, its two requesters,
// the shared ALU and the response consumer.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             r0_valid;
  logic             r0_ready;
  logic [2:0]       r0_op;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic [4:0]       r0_sa;

  logic             r1_valid;
  logic             r1_ready;
  logic [2:0]       r1_op;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;
  logic [4:0]       r1_sa;

  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_sa;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_illegal;

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b, r0_sa,
    output r0_ready,
    input  r1_valid, r1_op, r1_a, r1_b, r1_sa,
    output r1_ready,
    output alu_op, alu_a, alu_b, alu_sa,
    input  alu_result, alu_zero,
    output resp_valid, resp_id, resp_result,
    output resp_zero, resp_illegal,
    input  resp_ready
  );

  modport master (
    output r0_valid, r0_op, r0_a, r0_b, r0_sa,
    input  r0_ready,
    output r1_valid, r1_op, r1_a, r1_b, r1_sa,
    input  r1_ready,
    input  alu_op, alu_a, alu_b, alu_sa,
    output alu_result, alu_zero,
    input  resp_valid, resp_id, resp_result,
    input  resp_zero, resp_illegal,
    output resp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for the shared combinational ALU.
// One op in flight: IDLE accepts, EXEC captures, RESP hands off.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int RR_EN = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       sa_q;
  logic             id_q;

  logic             res_id_q;
  logic [WIDTH-1:0] res_q;
  logic             res_zero_q;
  logic             res_ill_q;

  logic g0;
  logic g1;
  logic acc0;
  logic acc1;
  logic accept;
  logic illegal;

  // r0 wins unless r1 is also pending and r0 was granted last in RR mode
  always_comb begin
    g0 = bus.r0_valid &
         (~bus.r1_valid | (RR_EN == 0) | last_q);
    g1 = bus.r1_valid & ~g0;
  end

  assign acc0   = reset_n & (state_q == IDLE) & g0;
  assign acc1   = reset_n & (state_q == IDLE) & g1;
  assign accept = acc0 | acc1;

  assign bus.r0_ready = acc0;
  assign bus.r1_ready = acc1;

  assign illegal = (op_q[2:1] == 2'b11);

  assign bus.alu_op = op_q;
  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;
  assign bus.alu_sa = sa_q;

  assign bus.resp_valid   = (state_q == RESP);
  assign bus.resp_id      = res_id_q;
  assign bus.resp_result  = res_q;
  assign bus.resp_zero    = res_zero_q;
  assign bus.resp_illegal = res_ill_q;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state: EXEC is always a single cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // issue registers and grant history, loaded on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sa_q   <= '0;
      id_q   <= 1'b0;
    end else if (accept) begin
      last_q <= acc1;
      id_q   <= acc1;
      op_q   <= acc1 ? bus.r1_op : bus.r0_op;
      a_q    <= acc1 ? bus.r1_a  : bus.r0_a;
      b_q    <= acc1 ? bus.r1_b  : bus.r0_b;
      sa_q   <= acc1 ? bus.r1_sa : bus.r0_sa;
    end
  end

  // response capture; illegal ops ignore the ALU and report zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_id_q   <= 1'b0;
      res_q      <= '0;
      res_zero_q <= 1'b0;
      res_ill_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      res_id_q   <= id_q;
      res_q      <= illegal ? '0 : bus.alu_result;
      res_zero_q <= illegal | bus.alu_zero;
      res_ill_q  <= illegal;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: RR and fixed-priority
// instances, each with a behavioural ALU on its bus.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_share_arbiter_if #(.WIDTH(W)) b0 ();
  alu_share_arbiter_if #(.WIDTH(W)) b1 ();

  alu_share_arbiter #(.WIDTH(W), .RR_EN(1)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0.slave)
  );

  alu_share_arbiter #(.WIDTH(W), .RR_EN(0)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(
    input logic [2:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [4:0]   sa
  );
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ~a;
      3'd5: return a << sa;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign b0.alu_result = alu_f(b0.alu_op, b0.alu_a,
                               b0.alu_b, b0.alu_sa);
  assign b0.alu_zero   = (b0.alu_result == '0);
  assign b1.alu_result = alu_f(b1.alu_op, b1.alu_a,
                               b1.alu_b, b1.alu_sa);
  assign b1.alu_zero   = (b1.alu_result == '0);

  task automatic drive0(input logic v, input logic [2:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [4:0] sa);
    b0.r0_valid = v; b0.r0_op = op;
    b0.r0_a = a; b0.r0_b = b; b0.r0_sa = sa;
  endtask

  task automatic drive1(input logic v, input logic [2:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [4:0] sa);
    b0.r1_valid = v; b0.r1_op = op;
    b0.r1_a = a; b0.r1_b = b; b0.r1_sa = sa;
  endtask

  task automatic test_reset;
    drive0(1'b1, 3'd0, 32'd1, 32'd1, 5'd0);
    drive1(1'b1, 3'd0, 32'd1, 32'd1, 5'd0);
    @(negedge clk);
    n_checks++;
    if (b0.r0_ready !== 1'b0 || b0.r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b%b want 00",
               b0.r0_ready, b0.r1_ready);
    end
    n_checks++;
    if (b0.resp_valid !== 1'b0 || b0.resp_result !== '0 ||
        b0.resp_id !== 1'b0 || b0.resp_zero !== 1'b0 ||
        b0.resp_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: valid=%b res=%h want 0 0",
               b0.resp_valid, b0.resp_result);
    end
    n_checks++;
    if (b0.alu_op !== 3'd0 || b0.alu_a !== '0 ||
        b0.alu_b !== '0 || b0.alu_sa !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_alu: a=%h b=%h want 0 0",
               b0.alu_a, b0.alu_b);
    end
    drive0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    drive1(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    b0.resp_ready = 1'b1;
    drive0(1'b1, 3'd0, 32'd5, 32'd7, 5'd0);
    #1;
    n_checks++;
    if (b0.r0_ready !== 1'b1 || b0.r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got %b%b want 10",
               b0.r0_ready, b0.r1_ready);
    end
    @(negedge clk);
    b0.r0_valid = 1'b0;
    n_checks++;
    if (b0.resp_valid !== 1'b0 || b0.alu_a !== 32'd5 ||
        b0.alu_b !== 32'd7 || b0.alu_op !== 3'd0) begin
      n_fail++;
      $display("FAIL single_exec: rv=%b a=%h b=%h want 0 5 7",
               b0.resp_valid, b0.alu_a, b0.alu_b);
    end
    @(negedge clk);
    n_checks++;
    if (b0.resp_valid !== 1'b1 || b0.resp_result !== 32'd12 ||
        b0.resp_zero !== 1'b0 || b0.resp_id !== 1'b0 ||
        b0.resp_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp: rv=%b res=%h z=%b id=%b want 1 c 0 0",
               b0.resp_valid, b0.resp_result,
               b0.resp_zero, b0.resp_id);
    end
    @(negedge clk);
    n_checks++;
    if (b0.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: rv=%b want 0", b0.resp_valid);
    end
  endtask

  task automatic test_round_robin;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    b0.resp_ready = 1'b1;
    drive0(1'b1, 3'd1, 32'd9, 32'd9, 5'd0);
    drive1(1'b1, 3'd1, 32'd9, 32'd9, 5'd0);
    #1;
    n_checks++;
    if (b0.r0_ready !== 1'b1 || b0.r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_tie1: got %b%b want 10",
               b0.r0_ready, b0.r1_ready);
    end
    @(negedge clk);
    n_checks++;
    if (b0.r0_ready !== 1'b0 || b0.r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_exec_ready: got %b%b want 00",
               b0.r0_ready, b0.r1_ready);
    end
    @(negedge clk);
    n_checks++;
    if (b0.resp_valid !== 1'b1 || b0.resp_id !== 1'b0 ||
        b0.resp_result !== '0 || b0.resp_zero !== 1'b1 ||
        b0.r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_resp1: rv=%b id=%b res=%h z=%b want 1 0 0 1",
               b0.resp_valid, b0.resp_id,
               b0.resp_result, b0.resp_zero);
    end
    @(negedge clk);
    n_checks++;
    if (b0.r1_ready !== 1'b1 || b0.r0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_tie2: got %b%b want 01",
               b0.r0_ready, b0.r1_ready);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (b0.resp_valid !== 1'b1 || b0.resp_id !== 1'b1 ||
        b0.resp_result !== '0 || b0.resp_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_resp2: rv=%b id=%b res=%h z=%b want 1 1 0 1",
               b0.resp_valid, b0.resp_id,
               b0.resp_result, b0.resp_zero);
    end
    @(negedge clk);
    n_checks++;
    if (b0.r0_ready !== 1'b1 || b0.r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_tie3: got %b%b want 10",
               b0.r0_ready, b0.r1_ready);
    end
    drive0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    drive1(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    n_checks++;
    if (b0.resp_valid !== 1'b0 || b0.alu_op !== 3'd1) begin
      n_fail++;
      $display("FAIL rr_withdraw: rv=%b op=%0d want 0 1",
               b0.resp_valid, b0.alu_op);
    end
  endtask

  task automatic test_fixed_priority;
    int g0;
    int g1;
    g0 = 0;
    g1 = 0;
    b1.resp_ready = 1'b1;
    b1.r0_valid = 1'b1; b1.r0_op = 3'd0;
    b1.r0_a = 32'd1; b1.r0_b = 32'd1; b1.r0_sa = 5'd0;
    b1.r1_valid = 1'b1; b1.r1_op = 3'd0;
    b1.r1_a = 32'd2; b1.r1_b = 32'd2; b1.r1_sa = 5'd0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (b1.r0_ready === 1'b1) g0++;
      if (b1.r1_ready === 1'b1) g1++;
      @(negedge clk);
    end
    b1.r0_valid = 1'b0;
    b1.r1_valid = 1'b0;
    n_checks++;
    if (g1 !== 0) begin
      n_fail++;
      $display("FAIL fp_r1_grants: got %0d want 0", g1);
    end
    n_checks++;
    if (g0 !== 3) begin
      n_fail++;
      $display("FAIL fp_r0_grants: got %0d want 3", g0);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    b0.resp_ready = 1'b0;
    drive1(1'b1, 3'd5, 32'h8000_0001, 32'd0, 5'd1);
    #1;
    n_checks++;
    if (b0.r1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: got %b want 1", b0.r1_ready);
    end
    @(negedge clk);
    b0.r1_valid = 1'b0;
    drive0(1'b1, 3'd0, 32'd3, 32'd4, 5'd0);
    n_checks++;
    if (b0.alu_op !== 3'd5 || b0.alu_sa !== 5'd1 ||
        b0.alu_a !== 32'h8000_0001) begin
      n_fail++;
      $display("FAIL bp_exec: op=%0d sa=%0d a=%h want 5 1 80000001",
               b0.alu_op, b0.alu_sa, b0.alu_a);
    end
    @(negedge clk);
    n_checks++;
    if (b0.resp_valid !== 1'b1 || b0.resp_id !== 1'b1 ||
        b0.resp_result !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL bp_resp: rv=%b id=%b res=%h want 1 1 00000002",
               b0.resp_valid, b0.resp_id, b0.resp_result);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (b0.resp_valid !== 1'b1 ||
          b0.resp_result !== 32'h0000_0002 ||
          b0.resp_id !== 1'b1 || b0.r0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: rv=%b res=%h rdy=%b want 1 2 0",
                 i, b0.resp_valid, b0.resp_result, b0.r0_ready);
      end
    end
    b0.resp_ready = 1'b1;
    #1;
    n_checks++;
    if (b0.r0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_same_cycle: got %b want 0", b0.r0_ready);
    end
    @(negedge clk);
    n_checks++;
    if (b0.r0_ready !== 1'b1 || b0.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next: rdy=%b rv=%b want 1 0",
               b0.r0_ready, b0.resp_valid);
    end
    b0.r0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b0.resp_valid !== 1'b0 || b0.r0_ready !== 1'b0 ||
        b0.alu_op !== 3'd5) begin
      n_fail++;
      $display("FAIL bp_withdraw: rv=%b rdy=%b op=%0d want 0 0 5",
               b0.resp_valid, b0.r0_ready, b0.alu_op);
    end
  endtask

  task automatic test_illegal;
    b0.resp_ready = 1'b1;
    drive0(1'b1, 3'd6, 32'h123, 32'h456, 5'd0);
    #1;
    n_checks++;
    if (b0.r0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_accept: got %b want 1", b0.r0_ready);
    end
    @(negedge clk);
    b0.r0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b0.resp_illegal !== 1'b1 || b0.resp_result !== '0 ||
        b0.resp_zero !== 1'b1 || b0.resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_resp: ill=%b res=%h z=%b want 1 0 1",
               b0.resp_illegal, b0.resp_result, b0.resp_zero);
    end
    @(negedge clk);
    drive0(1'b1, 3'd3, 32'hF0, 32'h0F, 5'd0);
    #1;
    n_checks++;
    if (b0.r0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL or_accept: got %b want 1", b0.r0_ready);
    end
    @(negedge clk);
    b0.r0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b0.resp_result !== 32'hFF || b0.resp_illegal !== 1'b0 ||
        b0.resp_zero !== 1'b0 || b0.resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL or_resp: res=%h ill=%b z=%b want ff 0 0",
               b0.resp_result, b0.resp_illegal, b0.resp_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec;
    b0.resp_ready = 1'b1;
    drive0(1'b1, 3'd0, 32'd1, 32'd2, 5'd3);
    #1;
    n_checks++;
    if (b0.r0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_accept: got %b want 1", b0.r0_ready);
    end
    @(negedge clk);
    drive1(1'b1, 3'd0, 32'd4, 32'd4, 5'd0);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (b0.resp_valid !== 1'b0 || b0.resp_result !== '0 ||
        b0.r0_ready !== 1'b0 || b0.r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_outputs: rv=%b res=%h rdy=%b%b want 0 0 00",
               b0.resp_valid, b0.resp_result,
               b0.r0_ready, b0.r1_ready);
    end
    n_checks++;
    if (b0.alu_op !== 3'd0 || b0.alu_a !== '0 ||
        b0.alu_b !== '0 || b0.alu_sa !== 5'd0) begin
      n_fail++;
      $display("FAIL rx_alu: a=%h b=%h sa=%0d want 0 0 0",
               b0.alu_a, b0.alu_b, b0.alu_sa);
    end
    @(negedge clk);
    n_checks++;
    if (b0.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_no_resp: rv=%b want 0", b0.resp_valid);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (b0.r0_ready !== 1'b1 || b0.r1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_tie: got %b%b want 10",
               b0.r0_ready, b0.r1_ready);
    end
    drive0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    drive1(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
  endtask

  initial begin
    b0.resp_ready = 1'b0;
    b1.resp_ready = 1'b0;
    b1.r0_valid = 1'b0; b1.r0_op = 3'd0;
    b1.r0_a = '0; b1.r0_b = '0; b1.r0_sa = 5'd0;
    b1.r1_valid = 1'b0; b1.r1_op = 3'd0;
    b1.r1_a = '0; b1.r1_b = '0; b1.r1_sa = 5'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_illegal();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
